// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite geometry, ROM widths and colour key shared by the fetch path
package sprite_pkg;
  localparam int SPRITE_W    = 24;
  localparam int SPRITE_H    = 34;
  localparam int FRAME_SIZE  = SPRITE_W * SPRITE_H;
  localparam int WAIT_OFFSET = 3264;
  localparam int PIX_W       = 24;
  localparam int ADDR_W      = 19;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t TRANSPARENT = 24'hFF00FF;
endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - DEPTH-stage valid shift register with async active-low clear
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/sprite_pixel_fetch.sv
// rtl/sprite_pixel_fetch.sv - per-frame shadowed sprite ROM address generation and
// transparency-keyed pixel return, latency ROM_LAT+2 from pixel_req to pixel_valid
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pixel_req,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        player_x,
  input  logic [9:0]        player_y,
  input  logic [31:0]       animationOffset,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  pixel_t            rom_data,
  output pixel_t            pixel_color,
  output logic              pixel_valid,
  output logic              addr_overflow,
  output logic [15:0]       pixels_drawn
);
  logic [31:0] r_off;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_face;
  logic [15:0] r_cnt;

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic               w_hit;
  logic [9:0]         w_col;
  logic [31:0]        w_full;
  logic               w_ovf;
  logic               w_hit_d;
  logic               w_show;

  // 11-bit signed difference so a draw point left/above the sprite never wraps into range
  assign w_dx   = $signed({1'b0, draw_x}) - $signed({1'b0, r_x});
  assign w_dy   = $signed({1'b0, draw_y}) - $signed({1'b0, r_y});
  assign w_hit  = pixel_req && !w_dx[10] && (w_dx[9:0] < 10'(SPRITE_W))
                            && !w_dy[10] && (w_dy[9:0] < 10'(SPRITE_H));
  assign w_col  = r_face ? (10'(SPRITE_W - 1) - w_dx[9:0]) : w_dx[9:0];
  assign w_full = r_off + 32'(w_dy[9:0]) * 32'(SPRITE_W) + 32'(w_col);
  assign w_ovf  = |w_full[31:ADDR_W];

  // Frame shadows; a request in the frame_start cycle still sees the old values
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_off  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_face <= 1'b0;
    end else if (frame_start) begin
      r_off  <= animationOffset;
      r_x    <= player_x;
      r_y    <= player_y;
      r_face <= facing_left;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr      <= '0;
      rom_rd        <= 1'b0;
      addr_overflow <= 1'b0;
    end else begin
      rom_rd <= w_hit;
      if (w_hit) begin
        rom_addr <= w_full[ADDR_W-1:0];
      end
      addr_overflow <= frame_start ? 1'b0 : (addr_overflow | (w_hit & w_ovf));
    end
  end

  valid_delay #(
    .DEPTH (ROM_LAT)
  ) u_hit_dly (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_d     (rom_rd),
    .o_q     (w_hit_d)
  );

  assign w_show = w_hit_d && (rom_data != TRANSPARENT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pixel_valid  <= 1'b0;
      pixel_color  <= '0;
      r_cnt        <= '0;
      pixels_drawn <= '0;
    end else begin
      pixel_valid <= w_show;
      pixel_color <= w_show ? rom_data : '0;
      if (frame_start) begin
        pixels_drawn <= r_cnt;
        r_cnt        <= '0;
      end else if (pixel_valid && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
endmodule
